// File: rtl/count_seq_checker.sv
// count_seq_checker: checks that the monitored count advances by one each cycle, with wrap/error stats and a FAULT latch.
// Define COUNT_SEQ_CHECK_SAT_EN for saturating statistic counters; otherwise they wrap modulo 2^CW.
module count_seq_checker #(
   parameter int W         = 4,
   parameter int CW        = 8,
   parameter int ERR_LIMIT = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [W-1:0]  cnt_in,
   input  logic          load_in,
   input  logic          clear,
   output logic          wrap_pulse,
   output logic          err_pulse,
   output logic [CW-1:0] wrap_cnt,
   output logic [CW-1:0] err_cnt,
   output logic          fault,
   output logic [1:0]    state
);
   localparam int NW = $clog2(ERR_LIMIT + 1);
   localparam logic [NW-1:0] LIM = NW'(ERR_LIMIT);
`ifdef COUNT_SEQ_CHECK_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif
   typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, FAULT = 2'd2} state_t;
   state_t state_q, state_d;
   logic [W-1:0] prev_q, prev_d;
   logic [NW-1:0] consec_q, consec_d, consec_inc;
   logic [CW-1:0] wrap_cnt_q, wrap_cnt_d, err_cnt_q, err_cnt_d, wrap_inc, err_inc;
   logic wrap_pulse_q, wrap_pulse_d, err_pulse_q, err_pulse_d;
   logic in_seq;
   always_comb begin
      in_seq     = cnt_in == prev_q + W'(1);
      consec_inc = consec_q + NW'(1);
      wrap_inc   = (SAT && wrap_cnt_q == '1) ? wrap_cnt_q : wrap_cnt_q + CW'(1);
      err_inc    = (SAT && err_cnt_q == '1) ? err_cnt_q : err_cnt_q + CW'(1);
      state_d      = state_q;
      prev_d       = prev_q;
      consec_d     = consec_q;
      wrap_cnt_d   = wrap_cnt_q;
      err_cnt_d    = err_cnt_q;
      wrap_pulse_d = 1'b0;
      err_pulse_d  = 1'b0;
      if (clear) begin
         state_d    = IDLE;
         consec_d   = '0;
         wrap_cnt_d = '0;
         err_cnt_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               prev_d  = cnt_in;
               state_d = TRACK;
            end
            TRACK: begin
               prev_d = cnt_in;
               if (load_in || in_seq) begin
                  consec_d = '0;
                  // a legal step into zero is the wrap event
                  if (!load_in && prev_q == '1) begin
                     wrap_pulse_d = 1'b1;
                     wrap_cnt_d   = wrap_inc;
                  end
               end else begin
                  err_pulse_d = 1'b1;
                  err_cnt_d   = err_inc;
                  consec_d    = consec_inc;
                  state_d     = consec_inc == LIM ? FAULT : TRACK;
               end
            end
            FAULT: state_d = FAULT;
            default: state_d = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         prev_q       <= '0;
         consec_q     <= '0;
         wrap_cnt_q   <= '0;
         err_cnt_q    <= '0;
         wrap_pulse_q <= 1'b0;
         err_pulse_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         prev_q       <= prev_d;
         consec_q     <= consec_d;
         wrap_cnt_q   <= wrap_cnt_d;
         err_cnt_q    <= err_cnt_d;
         wrap_pulse_q <= wrap_pulse_d;
         err_pulse_q  <= err_pulse_d;
      end
   end
   assign wrap_pulse = wrap_pulse_q;
   assign err_pulse  = err_pulse_q;
   assign wrap_cnt   = wrap_cnt_q;
   assign err_cnt    = err_cnt_q;
   assign fault      = state_q == FAULT;
   assign state      = state_q;
endmodule

// File: tb/tb_count_seq_checker.sv
// tb_count_seq_checker: directed checks of count_seq_checker with W=4, CW=8, ERR_LIMIT=3.
module tb_count_seq_checker;
   logic clk = 1'b0, rst = 1'b1, load_in = 1'b0, clear = 1'b0;
   logic [3:0] cnt_in = '0;
   logic wrap_pulse, err_pulse, fault;
   logic [7:0] wrap_cnt, err_cnt;
   logic [1:0] state;
   int n_run = 0, n_fail = 0;
   int n_wrap_p = 0, n_err_p = 0;
   count_seq_checker #(.W(4), .CW(8), .ERR_LIMIT(3)) dut (
      .clk(clk), .rst(rst), .cnt_in(cnt_in), .load_in(load_in), .clear(clear),
      .wrap_pulse(wrap_pulse), .err_pulse(err_pulse), .wrap_cnt(wrap_cnt),
      .err_cnt(err_cnt), .fault(fault), .state(state)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input int got, input int exp);
      n_run++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic step(input int c, input logic l, input logic cl);
      cnt_in  = 4'(c);
      load_in = l;
      clear   = cl;
      @(posedge clk);
      #1;
   endtask
   initial begin
      #2;
      chk("rst_state", int'(state), 0);
      chk("rst_fault", int'(fault), 0);
      chk("rst_wrap_cnt", int'(wrap_cnt), 0);
      chk("rst_err_cnt", int'(err_cnt), 0);
      chk("rst_pulses", int'({wrap_pulse, err_pulse}), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      step(5, 0, 0);
      chk("first_state", int'(state), 1);
      chk("first_no_err", int'(err_pulse), 0);
      for (int v = 6; v <= 16; v++) begin
         step(v, 0, 0);
         n_wrap_p += int'(wrap_pulse);
         n_err_p  += int'(err_pulse);
         if (v == 16) chk("wrap_at_zero", int'(wrap_pulse), 1);
      end
      step(1, 0, 0);
      n_wrap_p += int'(wrap_pulse);
      n_err_p  += int'(err_pulse);
      chk("wrap_pulses", n_wrap_p, 1);
      chk("no_err_pulses", n_err_p, 0);
      chk("wrap_cnt_1", int'(wrap_cnt), 1);
      chk("track_state", int'(state), 1);
      step(9, 1, 0);
      chk("load9_no_err", int'(err_pulse), 0);
      step(2, 1, 0);
      chk("load2_no_err", int'(err_pulse), 0);
      step(3, 0, 0);
      step(4, 0, 0);
      chk("after_load_err_cnt", int'(err_cnt), 0);
      chk("after_load_no_err", int'(err_pulse), 0);
      step(6, 0, 0);
      chk("skip_err_pulse", int'(err_pulse), 1);
      chk("skip_err_cnt", int'(err_cnt), 1);
      step(7, 0, 0);
      chk("resync_no_err", int'(err_pulse), 0);
      chk("skip_state", int'(state), 1);
      step(7, 0, 0);
      step(7, 0, 0);
      chk("consec_reset_state", int'(state), 1);
      chk("consec_err_cnt", int'(err_cnt), 3);
      step(7, 0, 1);
      chk("clear_state", int'(state), 0);
      chk("clear_err_cnt", int'(err_cnt), 0);
      chk("clear_wrap_cnt", int'(wrap_cnt), 0);
      step(8, 0, 0);
      chk("post_clear_track", int'(state), 1);
      step(8, 0, 0);
      chk("stall1_err", int'(err_pulse), 1);
      step(8, 0, 0);
      chk("stall2_state", int'(state), 1);
      step(8, 0, 0);
      chk("stall3_err", int'(err_pulse), 1);
      chk("stall3_err_cnt", int'(err_cnt), 3);
      chk("stall3_state", int'(state), 2);
      chk("stall3_fault", int'(fault), 1);
      step(8, 0, 0);
      chk("fault_no_err", int'(err_pulse), 0);
      chk("fault_frozen", int'(err_cnt), 3);
      step(3, 1, 0);
      chk("fault_ignores_load", int'(state), 2);
      step(3, 1, 1);
      chk("clear_exit_fault", int'(state), 0);
      chk("clear_exit_fault_flag", int'(fault), 0);
      chk("clear_exit_err_cnt", int'(err_cnt), 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0);
      chk("refault_state", int'(state), 2);
      chk("refault_err_cnt", int'(err_cnt), 3);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_fault", int'(fault), 0);
      chk("async_rst_state", int'(state), 0);
      chk("async_rst_err_cnt", int'(err_cnt), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      step(0, 0, 0);
      for (int i = 1; i <= 300 * 16; i++) step(i % 16, 0, 0);
`ifdef COUNT_SEQ_CHECK_SAT_EN
      chk("wrap_cnt_300", int'(wrap_cnt), 255);
`else
      chk("wrap_cnt_300", int'(wrap_cnt), 44);
`endif
      chk("wrap_run_err_cnt", int'(err_cnt), 0);
      chk("wrap_run_state", int'(state), 1);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
